alarm_clock_multi: RTL and testbench
====================================

ALARM_CLOCK_MULTI -- requirements
Module: alarm_clock_multi

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
REQ-002 CLKS_PER_SEC, 1, clk cycles per one-second tick (>=1).
REQ-003 NUM_ALARMS, 4, number of independent alarm channels (1..16).
REQ-004 RING_SECS, 60, seconds an unacknowledged alarm rings before self-clearing (>=1).
REQ-005 SNOOZE_MINS, 5, snooze length in minutes (used only with SNOOZE_EN).
REQ-006 Ports SHALL be, one per line: name, direction, width, meaning.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 time_load  in  1  load time_in into the time-of-day counter.
REQ-010 time_in  in  17  packed hh[16:12] mm[11:6] ss[5:0].
REQ-011 alarm_wr  in  1  write alarm_idx channel registers.
REQ-012 alarm_idx  in  $clog2(NUM_ALARMS) (min 1)  target channel.
REQ-013 alarm_hhmm  in  11  alarm time, hh[10:6] mm[5:0].
REQ-014 alarm_en  in  1  enable bit written with alarm_wr.
REQ-015 ack  in  NUM_ALARMS  per-channel acknowledge.
REQ-016 snooze  in  NUM_ALARMS  per-channel snooze request.
REQ-017 time_out  out  17  current time, same packing as time_in.
REQ-018 sec_tick  out  1  one-cycle pulse per second.
REQ-019 load_err  out  1  one-cycle pulse on rejected load or write.
REQ-020 alarm_ring  out  NUM_ALARMS  channel ringing, registered.

Function
REQ-021 Prescaler SHALL count 0..CLKS_PER_SEC-1; sec_tick high in the cycle the count wraps.
REQ-022 On sec_tick: ss+1; ss 59->0 carries mm; mm 59->0 carries hh; hh 23->0 (23:59:59 -> 00:00:00).
REQ-023 time_load SHALL update time_out next cycle and clear the prescaler; a coincident tick is discarded.
REQ-024 time_load with hh>23, mm>59 or ss>59 SHALL be ignored and pulse load_err next cycle.
REQ-025 alarm_wr with hh>23 or mm>59 SHALL be ignored and pulse load_err; a valid write forces that channel to IDLE.
REQ-026 Channel FSM states: IDLE, RINGING, SNOOZED (SNOOZED only with SNOOZE_EN).
REQ-027 IDLE->RINGING when enabled and a tick advances time to alarm hh:mm:00; time_load never triggers a match.
REQ-028 RINGING: alarm_ring bit high; ack -> IDLE next cycle; RING_SECS ticks without ack -> IDLE.
REQ-029 RINGING + snooze -> SNOOZED (ring low); after SNOOZE_MINS*60 ticks -> RINGING with ring timer restarted.
REQ-030 SNOOZED + ack -> IDLE; ack and snooze in same cycle -> ack wins.
REQ-031 ack/snooze on an IDLE channel SHALL have no effect; a match coinciding with ack still starts ringing.
REQ-032 Multiple channels SHALL ring independently and simultaneously.

Reset
REQ-033 rst SHALL asynchronously clear time_out to 0, prescaler to 0, sec_tick, load_err, alarm_ring to 0, every channel to IDLE with alarm time 00:00 disabled, mid-operation included.

Configuration
REQ-034 Macro ALARM_CLOCK_SNOOZE_EN defined: SNOOZED state and per-channel snooze counter built.
REQ-035 Macro undefined: snooze port present but ignored, no SNOOZED state, SNOOZE_MINS unused.

Structure
REQ-036 Shared package clock_pkg SHALL hold HH_W=5, MM_W=6, SS_W=6, TIME_W=17, HH_MAX=23, MM_MAX=59, SS_MAX=59 and the channel state enum.
REQ-037 Per-channel FSM and its second counter SHALL be sub-module alarm_channel, generated NUM_ALARMS times.

Verification (CLKS_PER_SEC=4, NUM_ALARMS=4, RING_SECS=5)
REQ-038 Release rst -> time_out=0, alarm_ring=0; sec_tick every 4 clocks; after 4 ticks time_out=00:00:04.
REQ-039 Load 23:59:59, one tick -> 00:00:00; load 25:00:00 -> load_err pulse, time unchanged.
REQ-040 Ch2 alarm 00:01 enabled, load 00:00:58 -> ring[2]=1 after 2nd tick; ack[2] -> ring[2]=0 next cycle.
REQ-041 Same setup, no ack -> ring[2] drops after 5 ticks; ch0 and ch3 both set 00:01 ring together.
REQ-042 SNOOZE_EN, SNOOZE_MINS=1: snooze[2] while ringing -> ring 0, re-rings after 60 ticks; ack+snooze same cycle -> IDLE.
REQ-043 rst asserted mid-ring -> alarm_ring=0 and time_out=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/alarm_clock_multi_pkg.sv
// clock_pkg: shared time-field widths and limits, plus the alarm channel state encoding.
// The SNOOZED state exists only when ALARM_CLOCK_SNOOZE_EN is defined.
package clock_pkg;
    localparam int HH_W   = 5;
    localparam int MM_W   = 6;
    localparam int SS_W   = 6;
    localparam int TIME_W = 17;

    localparam logic [HH_W-1:0] HH_MAX = 5'd23;
    localparam logic [MM_W-1:0] MM_MAX = 6'd59;
    localparam logic [SS_W-1:0] SS_MAX = 6'd59;

`ifdef ALARM_CLOCK_SNOOZE_EN
    typedef enum logic [1:0] {CH_IDLE, CH_RINGING, CH_SNOOZED} ch_state_e;
`else
    typedef enum logic {CH_IDLE, CH_RINGING} ch_state_e;
`endif
endpackage

// File: rtl/alarm_clock_multi_channel.sv
// alarm_channel: one alarm register set, its ring/snooze FSM and second counters.
// Snooze support is built only when ALARM_CLOCK_SNOOZE_EN is defined.
module alarm_channel
    import clock_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [HH_W+MM_W-1:0] wr_hhmm,
    input  logic                 wr_en,
    input  logic                 tick,
    input  logic                 min_tick,
    input  logic [HH_W+MM_W-1:0] tick_hhmm,
    input  logic                 ack,
    input  logic                 snooze,
    output logic                 ring
);
    localparam int RC_W = $clog2(RING_SECS + 1);
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECS - 1);

    ch_state_e              state, state_nx;
    logic [RC_W-1:0]        ring_cnt, ring_cnt_nx;
    logic [HH_W+MM_W-1:0]   alarm_hhmm;
    logic                   alarm_on;
    logic                   hit;

    // min_tick marks a tick that lands exactly on hh:mm:00; loads never produce it.
    assign hit  = alarm_on && min_tick && (tick_hhmm == alarm_hhmm);
    assign ring = (state == CH_RINGING);

`ifdef ALARM_CLOCK_SNOOZE_EN
    localparam int SNZ_TICKS = SNOOZE_MINS * 60;
    localparam int SC_W = $clog2(SNZ_TICKS + 1);
    localparam logic [SC_W-1:0] SNZ_LAST = SC_W'(SNZ_TICKS - 1);

    logic [SC_W-1:0] snz_cnt, snz_cnt_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) snz_cnt <= '0;
        else     snz_cnt <= snz_cnt_nx;
    end
`else
    logic unused_snooze;
    localparam int UNUSED_SNOOZE_MINS = SNOOZE_MINS;
    assign unused_snooze = snooze;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CH_IDLE;
            ring_cnt   <= '0;
            alarm_hhmm <= '0;
            alarm_on   <= 1'b0;
        end else begin
            state    <= state_nx;
            ring_cnt <= ring_cnt_nx;
            if (wr) begin
                alarm_hhmm <= wr_hhmm;
                alarm_on   <= wr_en;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        ring_cnt_nx = ring_cnt;
`ifdef ALARM_CLOCK_SNOOZE_EN
        snz_cnt_nx  = snz_cnt;
`endif
        if (wr) begin
            state_nx = CH_IDLE;
        end else begin
            case (state)
                CH_IDLE: begin
                    if (hit) begin
                        state_nx    = CH_RINGING;
                        ring_cnt_nx = '0;
                    end
                end
                CH_RINGING: begin
                    if (ack) begin
                        state_nx = CH_IDLE;
`ifdef ALARM_CLOCK_SNOOZE_EN
                    end else if (snooze) begin
                        state_nx   = CH_SNOOZED;
                        snz_cnt_nx = '0;
`endif
                    end else if (tick) begin
                        if (ring_cnt == RING_LAST) state_nx = CH_IDLE;
                        else                       ring_cnt_nx = ring_cnt + 1'b1;
                    end
                end
`ifdef ALARM_CLOCK_SNOOZE_EN
                CH_SNOOZED: begin
                    if (ack) begin
                        state_nx = CH_IDLE;
                    end else if (tick) begin
                        if (snz_cnt == SNZ_LAST) begin
                            state_nx    = CH_RINGING;
                            ring_cnt_nx = '0;
                        end else begin
                            snz_cnt_nx = snz_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: state_nx = CH_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: time-of-day counter with NUM_ALARMS independent alarm channels.
// Define ALARM_CLOCK_SNOOZE_EN to build per-channel snooze support.
module alarm_clock_multi
    import clock_pkg::*;
#(
    parameter int CLKS_PER_SEC = 1,
    parameter int NUM_ALARMS   = 4,
    parameter int RING_SECS    = 60,
    parameter int SNOOZE_MINS  = 5,
    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  time_load,
    input  logic [TIME_W-1:0]     time_in,
    input  logic                  alarm_wr,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic [HH_W+MM_W-1:0]  alarm_hhmm,
    input  logic                  alarm_en,
    input  logic [NUM_ALARMS-1:0] ack,
    input  logic [NUM_ALARMS-1:0] snooze,
    output logic [TIME_W-1:0]     time_out,
    output logic                  sec_tick,
    output logic                  load_err,
    output logic [NUM_ALARMS-1:0] alarm_ring
);
    localparam int PS_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_SEC - 1);

    logic [PS_W-1:0] ps_cnt;
    logic [HH_W-1:0] hh, hh_nx;
    logic [MM_W-1:0] mm, mm_nx;
    logic [SS_W-1:0] ss, ss_nx;
    logic            load_ok, wr_ok, ps_wrap, tick_now, min_tick;

    assign load_ok  = time_load && (time_in[16:12] <= HH_MAX) &&
                      (time_in[11:6] <= MM_MAX) && (time_in[5:0] <= SS_MAX);
    assign wr_ok    = alarm_wr && (alarm_hhmm[10:6] <= HH_MAX) &&
                      (alarm_hhmm[5:0] <= MM_MAX) && (int'(alarm_idx) < NUM_ALARMS);
    assign ps_wrap  = (ps_cnt == PS_LAST);
    // A valid load restarts the second, so a tick in the same cycle is dropped.
    assign tick_now = ps_wrap && !load_ok;
    assign min_tick = tick_now && (ss_nx == '0);
    assign time_out = {hh, mm, ss};

    always_comb begin
        hh_nx = hh;
        mm_nx = mm;
        ss_nx = ss + 1'b1;
        if (ss == SS_MAX) begin
            ss_nx = '0;
            mm_nx = mm + 1'b1;
            if (mm == MM_MAX) begin
                mm_nx = '0;
                hh_nx = (hh == HH_MAX) ? '0 : hh + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt   <= '0;
            hh       <= '0;
            mm       <= '0;
            ss       <= '0;
            sec_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= tick_now;
            load_err <= (time_load && !load_ok) || (alarm_wr && !wr_ok);
            if (load_ok) begin
                ps_cnt       <= '0;
                {hh, mm, ss} <= time_in;
            end else begin
                ps_cnt <= ps_wrap ? '0 : ps_cnt + 1'b1;
                if (ps_wrap) begin
                    hh <= hh_nx;
                    mm <= mm_nx;
                    ss <= ss_nx;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        alarm_channel #(
            .RING_SECS  (RING_SECS),
            .SNOOZE_MINS(SNOOZE_MINS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr_ok && (alarm_idx == IDX_W'(i))),
            .wr_hhmm  (alarm_hhmm),
            .wr_en    (alarm_en),
            .tick     (tick_now),
            .min_tick (min_tick),
            .tick_hhmm({hh_nx, mm_nx}),
            .ack      (ack[i]),
            .snooze   (snooze[i]),
            .ring     (alarm_ring[i])
        );
    end
endmodule

// File: tb/tb_alarm_clock_multi.sv
// Self-checking bench for alarm_clock_multi: vector table, directed alarm sequences
// and randomized traffic against a seconds-of-day reference model.
module tb_alarm_clock_multi;
    localparam int CPS = 4;
    localparam int NA  = 4;
    localparam int RS  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        time_load;
    logic [16:0] time_in;
    logic        alarm_wr;
    logic [1:0]  alarm_idx;
    logic [10:0] alarm_hhmm;
    logic        alarm_en;
    logic [3:0]  ack;
    logic [3:0]  snooze;
    logic [16:0] time_out;
    logic        sec_tick;
    logic        load_err;
    logic [3:0]  alarm_ring;

    alarm_clock_multi #(
        .CLKS_PER_SEC(CPS), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MINS(1)
    ) dut (
        .clk(clk), .rst(rst), .time_load(time_load), .time_in(time_in),
        .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hhmm(alarm_hhmm),
        .alarm_en(alarm_en), .ack(ack), .snooze(snooze), .time_out(time_out),
        .sec_tick(sec_tick), .load_err(load_err), .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time as seconds of day, each channel as ticks left to ring.
    int m_sod, m_ph;
    bit m_tick, m_err;
    int m_amin [NA];
    bit m_aen  [NA];
    int m_left [NA];

    function automatic logic [16:0] T(int h, int m, int s);
        return {h[4:0], m[5:0], s[5:0]};
    endfunction

    function automatic logic [10:0] A(int h, int m);
        return {h[4:0], m[5:0]};
    endfunction

    function automatic logic [16:0] enc(int sod);
        return T(sod / 3600, (sod / 60) % 60, sod % 60);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s cycle budget expired", name);
    endtask

    task automatic model_reset();
        m_sod = 0; m_ph = 0; m_tick = 0; m_err = 0;
        for (int i = 0; i < NA; i++) begin
            m_amin[i] = 0; m_aen[i] = 0; m_left[i] = 0;
        end
    endtask

    task automatic model_step();
        int h, m, s;
        bit lv, wv, tk;
        h  = int'(time_in[16:12]); m = int'(time_in[11:6]); s = int'(time_in[5:0]);
        lv = time_load && h < 24 && m < 60 && s < 60;
        wv = alarm_wr && int'(alarm_hhmm[10:6]) < 24 && int'(alarm_hhmm[5:0]) < 60;
        tk = (m_ph == CPS - 1) && !lv;
        m_err = (time_load && !lv) || (alarm_wr && !wv);
        if (lv) begin
            m_sod = h * 3600 + m * 60 + s;
            m_ph  = 0;
        end else begin
            m_ph = (m_ph + 1) % CPS;
            if (tk) m_sod = (m_sod + 1) % 86400;
        end
        for (int i = 0; i < NA; i++) begin
            if (wv && int'(alarm_idx) == i) begin
                m_amin[i] = int'(alarm_hhmm[10:6]) * 60 + int'(alarm_hhmm[5:0]);
                m_aen[i]  = alarm_en;
                m_left[i] = 0;
            end else if (m_left[i] > 0) begin
                if (ack[i])  m_left[i] = 0;
                else if (tk) m_left[i] = m_left[i] - 1;
            end else if (m_aen[i] && tk && m_sod % 60 == 0 && m_sod / 60 == m_amin[i]) begin
                m_left[i] = RS;
            end
        end
        m_tick = tk;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] r;
        for (int i = 0; i < NA; i++) r[i] = (m_left[i] > 0);
        chk({tag, "_time"}, 32'(time_out), 32'(enc(m_sod)));
        chk({tag, "_tick"}, 32'(sec_tick), 32'(m_tick));
        chk({tag, "_err"},  32'(load_err), 32'(m_err));
        chk({tag, "_ring"}, 32'(alarm_ring), 32'(r));
    endtask

    task automatic idle_in();
        time_load = 0; time_in = '0; alarm_wr = 0; alarm_idx = '0;
        alarm_hhmm = '0; alarm_en = 0; ack = '0; snooze = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic write_alarm(input int idx, input logic [10:0] hm);
        idle_in(); alarm_wr = 1; alarm_idx = 2'(idx); alarm_hhmm = hm; alarm_en = 1;
        cycle(); idle_in();
    endtask

    task automatic load_time(input logic [16:0] t);
        idle_in(); time_load = 1; time_in = t;
        cycle(); idle_in();
    endtask

    task automatic wait_ring(input logic [3:0] mask, input int budget, output int ticks);
        bit hit;
        ticks = 0; hit = 0;
        for (int c = 0; c < budget && !hit; c++) begin
            cycle();
            if (sec_tick) ticks++;
            if ((alarm_ring & mask) != 0) hit = 1;
        end
        if (!hit) timeout_fail("ring_wait");
    endtask

    typedef struct {
        logic        ld;
        logic [16:0] tin;
        logic        wr;
        logic [1:0]  idx;
        logic [10:0] hhmm;
        logic [16:0] exp_t;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int  tk;
        bit  done;

        vecs[0]  = '{1, T(23,59,59), 0, 0, A(0,0),  T(23,59,59), 0};
        vecs[1]  = '{0, T(0,0,0),    0, 0, A(0,0),  T(23,59,59), 0};
        vecs[2]  = '{0, T(0,0,0),    0, 0, A(0,0),  T(23,59,59), 0};
        vecs[3]  = '{0, T(0,0,0),    0, 0, A(0,0),  T(23,59,59), 0};
        vecs[4]  = '{0, T(0,0,0),    0, 0, A(0,0),  T(0,0,0),    0};
        vecs[5]  = '{1, T(25,0,0),   0, 0, A(0,0),  T(0,0,0),    1};
        vecs[6]  = '{0, T(0,0,0),    0, 0, A(0,0),  T(0,0,0),    0};
        vecs[7]  = '{1, T(12,60,0),  0, 0, A(0,0),  T(0,0,0),    1};
        vecs[8]  = '{0, T(0,0,0),    1, 1, A(24,0), T(0,0,1),    1};
        vecs[9]  = '{0, T(0,0,0),    1, 1, A(10,61),T(0,0,1),    1};
        vecs[10] = '{1, T(10,20,30), 0, 0, A(0,0),  T(10,20,30), 0};
        vecs[11] = '{1, T(23,59,60), 0, 0, A(0,0),  T(10,20,30), 1};

        idle_in();
        rst = 1;
        #12;
        @(negedge clk);
        rst = 0;
        model_reset();
        chk("rst_time", 32'(time_out), 0);
        chk("rst_ring", 32'(alarm_ring), 0);
        chk("rst_tick", 32'(sec_tick), 0);
        chk("rst_err",  32'(load_err), 0);

        tk = 0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (sec_tick) tk++;
            check_model("free_run");
        end
        chk("four_ticks_count", 32'(tk), 4);
        chk("four_ticks_time", 32'(time_out), 32'(T(0,0,4)));

        for (int v = 0; v < 12; v++) begin
            idle_in();
            time_load = vecs[v].ld; time_in = vecs[v].tin;
            alarm_wr = vecs[v].wr; alarm_idx = vecs[v].idx; alarm_hhmm = vecs[v].hhmm;
            alarm_en = 1;
            cycle();
            chk($sformatf("vec%0d_time", v), 32'(time_out), 32'(vecs[v].exp_t));
            chk($sformatf("vec%0d_err", v),  32'(load_err), 32'(vecs[v].exp_err));
        end
        idle_in();

        // Single channel rings on the minute, ack clears it.
        write_alarm(2, A(0,1));
        load_time(T(0,0,58));
        wait_ring(4'b0100, 40, tk);
        chk("ring2_ticks", 32'(tk), 2);
        chk("ring2_bits", 32'(alarm_ring), 32'(4'b0100));
        chk("ring2_time", 32'(time_out), 32'(T(0,1,0)));
        chk("ring2_on_tick", 32'(sec_tick), 1);
        ack = 4'b0100;
        cycle();
        ack = '0;
        chk("ack_clears", 32'(alarm_ring), 0);
        check_model("after_ack");

        // Three channels ring together and self-clear after RS ticks.
        write_alarm(0, A(0,1));
        write_alarm(3, A(0,1));
        load_time(T(0,0,58));
        wait_ring(4'b1101, 40, tk);
        chk("multi_ring", 32'(alarm_ring), 32'(4'b1101));
        tk = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            cycle();
            if (sec_tick) tk++;
            if (alarm_ring == '0) done = 1;
        end
        if (!done) timeout_fail("self_clear");
        chk("self_clear_ticks", 32'(tk), RS);
        check_model("after_clear");

        for (int c = 0; c < 800; c++) begin
            idle_in();
            if ($urandom_range(0, 31) == 0) begin
                time_load = 1;
                time_in = T(($urandom_range(0, 7) == 0) ? 24 : int'($urandom_range(0, 1)),
                            int'($urandom_range(0, 2)), int'($urandom_range(50, 60)));
            end
            if ($urandom_range(0, 15) == 0) begin
                alarm_wr = 1;
                alarm_idx = 2'($urandom);
                alarm_hhmm = A(($urandom_range(0, 7) == 0) ? 24 : int'($urandom_range(0, 1)),
                               ($urandom_range(0, 7) == 0) ? 61 : int'($urandom_range(0, 3)));
                alarm_en = ($urandom_range(0, 3) != 0);
            end
            ack = 4'($urandom) & 4'($urandom) & 4'($urandom);
`ifndef ALARM_CLOCK_SNOOZE_EN
            snooze = 4'($urandom);
`endif
            cycle();
            check_model("rand");
        end
        idle_in();

`ifdef ALARM_CLOCK_SNOOZE_EN
        write_alarm(2, A(0,1));
        load_time(T(0,0,58));
        wait_ring(4'b0100, 40, tk);
        snooze = 4'b0100;
        cycle();
        snooze = '0;
        chk("snooze_off", 32'(alarm_ring[2]), 0);
        tk = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            cycle();
            if (sec_tick) tk++;
            if (alarm_ring[2]) done = 1;
        end
        if (!done) timeout_fail("snooze_rering");
        chk("snooze_ticks", 32'(tk), 60);
        ack = 4'b0100; snooze = 4'b0100;
        cycle();
        idle_in();
        chk("ack_beats_snooze", 32'(alarm_ring[2]), 0);
`endif

        // Asynchronous reset while a channel rings.
        write_alarm(2, A(0,1));
        load_time(T(0,0,58));
        wait_ring(4'b0100, 40, tk);
        chk("pre_rst_ring", 32'(alarm_ring[2]), 1);
        #2 rst = 1;
        #1;
        chk("async_rst_ring", 32'(alarm_ring), 0);
        chk("async_rst_time", 32'(time_out), 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        cycle();
        check_model("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
